// File: rtl/sobel_frame_sequencer.sv
// Frame-level sequencer: streams a frame into BRAM0, kicks the Sobel FSM,
// waits for its done (with timeout), then drains BRAM1 onto an output stream.
module sobel_frame_sequencer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned IMAGE_WIDTH    = 100,
    parameter int unsigned IMAGE_HEIGHT   = 100,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_mode,
    input  logic [ADDR_WIDTH-1:0] i_num_pix,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  b0_ce2,
    output logic                  b0_we2,
    output logic [ADDR_WIDTH-1:0] b0_addr2,
    output logic [DATA_WIDTH-1:0] b0_d2,
    output logic                  b1_ce2,
    output logic                  b1_we2,
    output logic [ADDR_WIDTH-1:0] b1_addr2,
    input  logic [DATA_WIDTH-1:0] b1_q2,
    output logic                  o_f_en,
    output logic                  o_f_run,
    output logic [ADDR_WIDTH-1:0] o_f_num_cnt,
    input  logic                  i_f_idle,
    input  logic                  i_f_done,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_err
);

    localparam int unsigned TIMER_WIDTH = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0]  FRAME_PIX  = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0]  ONE        = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 state;
    logic                   cap_mode;
    logic [ADDR_WIDTH-1:0]  cap_num;
    logic [ADDR_WIDTH-1:0]  wr_cnt;
    logic [ADDR_WIDTH-1:0]  rd_cnt;
    logic [ADDR_WIDTH-1:0]  out_cnt;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   rd_pend;
    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   f_en;
    logic                   err;

    logic load_acc;
    logic out_acc;
    logic rd_issue;
    logic filter_phase;

    assign load_acc     = (state == ST_LOAD) && s_valid;
    assign out_acc      = out_valid && m_ready;
    // One read in flight; the output register must be free (or emptying) when data lands.
    assign rd_issue     = (state == ST_DRAIN) && !rd_pend && (rd_cnt < cap_num)
                          && (!out_valid || m_ready);
    assign filter_phase = (state == ST_KICK) || (state == ST_WAIT) || (state == ST_DRAIN);

    assign s_ready      = (state == ST_LOAD);
    assign b0_ce2       = load_acc;
    assign b0_we2       = load_acc;
    assign b0_addr2     = load_acc ? wr_cnt : '0;
    assign b0_d2        = load_acc ? s_data : '0;

    assign b1_ce2       = rd_issue;
    assign b1_we2       = 1'b0;
    assign b1_addr2     = rd_issue ? rd_cnt : '0;

    assign o_f_en       = f_en;
    assign o_f_run      = filter_phase && cap_mode;
    assign o_f_num_cnt  = filter_phase ? cap_num : '0;

    assign m_valid      = out_valid;
    assign m_data       = out_data;
    assign o_busy       = (state != ST_IDLE);
    assign o_frame_done = (state == ST_DONE);
    assign o_err        = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cap_mode  <= 1'b0;
            cap_num   <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
            timer     <= '0;
            rd_pend   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            f_en      <= 1'b0;
            err       <= 1'b0;
        end else begin
            f_en <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        cap_mode <= i_mode;
                        cap_num  <= i_num_pix;
                        if ((i_num_pix == '0) || (i_mode && (i_num_pix != FRAME_PIX))) begin
                            err <= 1'b1;
                        end else begin
                            wr_cnt <= '0;
                            state  <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_acc) begin
                        wr_cnt <= wr_cnt + ONE;
                        if (wr_cnt == cap_num - ONE) begin
                            state <= ST_KICK;
                        end
                    end
                end
                ST_KICK: begin
                    if (i_f_idle) begin
                        f_en  <= 1'b1;
                        timer <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // done takes priority over a simultaneous timeout
                    if (i_f_done) begin
                        rd_cnt    <= '0;
                        out_cnt   <= '0;
                        rd_pend   <= 1'b0;
                        out_valid <= 1'b0;
                        state     <= ST_DRAIN;
                    end else if (timer == TIMER_LAST) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + TIMER_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    rd_pend <= rd_issue;
                    if (rd_issue) begin
                        rd_cnt <= rd_cnt + ONE;
                    end
                    if (rd_pend) begin
                        out_valid <= 1'b1;
                        out_data  <= b1_q2;
                    end else if (out_acc) begin
                        out_valid <= 1'b0;
                    end
                    if (out_acc) begin
                        out_cnt <= out_cnt + ONE;
                        if (out_cnt == cap_num - ONE) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for sobel_frame_sequencer with a behavioural filter and BRAM1 model.
module tb_sobel_frame_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned IW = 100;
    localparam int unsigned IH = 100;
    localparam int unsigned TO = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_mode = 1'b0;
    logic [AW-1:0] i_num_pix = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          b0_ce2, b0_we2;
    logic [AW-1:0] b0_addr2;
    logic [DW-1:0] b0_d2;
    logic          b1_ce2, b1_we2;
    logic [AW-1:0] b1_addr2;
    logic [DW-1:0] b1_q2 = '0;
    logic          o_f_en, o_f_run;
    logic [AW-1:0] o_f_num_cnt;
    logic          f_idle = 1'b1;
    logic          f_done = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          o_busy, o_frame_done, o_err;

    always #5 clk = ~clk;

    sobel_frame_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(IW),
        .IMAGE_HEIGHT(IH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode), .i_num_pix(i_num_pix),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .b0_ce2(b0_ce2), .b0_we2(b0_we2), .b0_addr2(b0_addr2), .b0_d2(b0_d2),
        .b1_ce2(b1_ce2), .b1_we2(b1_we2), .b1_addr2(b1_addr2), .b1_q2(b1_q2),
        .o_f_en(o_f_en), .o_f_run(o_f_run), .o_f_num_cnt(o_f_num_cnt),
        .i_f_idle(f_idle), .i_f_done(f_done),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
    );

    logic [74:0] all_out;
    assign all_out = {s_ready, b0_ce2, b0_we2, b0_addr2, b0_d2, b1_ce2, b1_we2, b1_addr2,
                      o_f_en, o_f_run, o_f_num_cnt, m_valid, m_data, o_busy, o_frame_done, o_err};

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] pix_in(input int unsigned k);
        return DW'((k * 13 + 5) ^ (k >> 8));
    endfunction

    function automatic logic [DW-1:0] pix_out(input int unsigned a);
        return DW'((a * 7 + 3) ^ (a >> 5));
    endfunction

    // Filter model: done pulse four cycles after the enable pulse unless suppressed.
    logic        never_done = 1'b0;
    int unsigned done_cd = 0;
    always @(posedge clk) begin
        f_done <= 1'b0;
        if (o_f_en && !never_done) begin
            done_cd <= 3;
        end else if (done_cd != 0) begin
            done_cd <= done_cd - 1;
            if (done_cd == 1) f_done <= 1'b1;
        end
    end

    // BRAM1 port-2 read model, one cycle latency.
    always @(posedge clk) begin
        if (b1_ce2) b1_q2 <= pix_out(32'(b1_addr2));
    end

    int st_in, st_out, st_bad_data, st_bad_stall, st_bad_b0, st_bad_b1;
    int st_en, st_en_cyc, st_idle_cyc, st_err, st_err_cyc, st_done, st_last_in_cyc;
    logic          st_en_run;
    logic [AW-1:0] st_en_num;
    logic          st_hung;

    task automatic start(input logic mode, input int unsigned num);
        @(posedge clk); #1;
        i_start   = 1'b1;
        i_mode    = mode;
        i_num_pix = AW'(num);
        @(posedge clk); #1;
        i_start   = 1'b0;
    endtask

    // Per-cycle driver and observer for one frame; leaves statistics for the caller to judge.
    task automatic run_frame(input int unsigned num, input bit toggle_valid, input int unsigned ready_pct,
                             input int unsigned idle_delay, input int unsigned abort_beats,
                             input int unsigned budget);
        int unsigned   rd_exp = 0;
        int unsigned   kick_wait = 0;
        logic          pv = 1'b0;
        logic          pr = 1'b0;
        logic [DW-1:0] pd = '0;
        bit            fin = 1'b0;
        bit            acc_in;
        st_in = 0; st_out = 0; st_bad_data = 0; st_bad_stall = 0; st_bad_b0 = 0; st_bad_b1 = 0;
        st_en = 0; st_en_cyc = -1; st_idle_cyc = -1; st_err = 0; st_err_cyc = -1; st_done = 0;
        st_last_in_cyc = -1; st_en_run = 1'b0; st_en_num = '0; st_hung = 1'b0;
        if (idle_delay != 0) f_idle = 1'b0;
        for (int cyc = 0; !fin; cyc++) begin
            s_valid = toggle_valid ? (cyc % 2 == 0) : 1'b1;
            s_data  = pix_in(st_in);
            m_ready = ($urandom_range(0, 99) < ready_pct);
            if (idle_delay != 0 && st_in == int'(num)) begin
                kick_wait++;
                if (kick_wait == idle_delay + 1) begin
                    f_idle = 1'b1;
                    st_idle_cyc = cyc;
                end
            end
            @(negedge clk);
            acc_in = s_valid && s_ready;
            if ((b0_ce2 || b0_we2) && !(acc_in && b0_ce2 && b0_we2 &&
                b0_addr2 == AW'(st_in) && b0_d2 == pix_in(st_in))) st_bad_b0++;
            if (acc_in && !(b0_ce2 && b0_we2)) st_bad_b0++;
            if (acc_in) begin
                st_in++;
                st_last_in_cyc = cyc;
            end
            if (b1_we2) st_bad_b1++;
            if (b1_ce2) begin
                if (b1_addr2 != AW'(rd_exp)) st_bad_b1++;
                rd_exp++;
            end
            if (pv && !pr && (!m_valid || m_data != pd)) st_bad_stall++;
            if (m_valid && m_ready) begin
                if (m_data != pix_out(st_out)) st_bad_data++;
                st_out++;
            end
            pv = m_valid; pr = m_ready; pd = m_data;
            if (o_f_en) begin
                if (st_en == 0) begin
                    st_en_cyc = cyc;
                    st_en_run = o_f_run;
                    st_en_num = o_f_num_cnt;
                end
                st_en++;
            end
            if (o_err) begin
                st_err++;
                st_err_cyc = cyc;
                fin = 1'b1;
            end
            if (o_frame_done) begin
                st_done++;
                fin = 1'b1;
            end
            if (abort_beats != 0 && st_out >= int'(abort_beats)) fin = 1'b1;
            if (cyc + 1 >= int'(budget)) begin
                st_hung = 1'b1;
                fin = 1'b1;
            end
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", all_out);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b s_ready=%b exp 0 0", o_busy, s_ready);
        end
    endtask

    task automatic test_move();
        start(1'b0, 16);
        run_frame(16, 1'b0, 100, 0, 0, 300);
        checks++;
        if (st_hung !== 1'b0) begin errors++; $display("FAIL move_hung got %b exp 0", st_hung); end
        checks++;
        if (st_in != 16 || st_last_in_cyc != 15) begin
            errors++; $display("FAIL move_load got in=%0d last=%0d exp 16 15", st_in, st_last_in_cyc);
        end
        checks++;
        if (st_bad_b0 != 0) begin errors++; $display("FAIL move_b0 got %0d bad exp 0", st_bad_b0); end
        checks++;
        if (st_en != 1 || st_en_run !== 1'b0 || st_en_num !== AW'(16)) begin
            errors++;
            $display("FAIL move_kick got en=%0d run=%b num=%0d exp 1 0 16", st_en, st_en_run, st_en_num);
        end
        checks++;
        if (st_out != 16 || st_bad_data != 0 || st_bad_b1 != 0) begin
            errors++;
            $display("FAIL move_drain got out=%0d bad=%0d b1bad=%0d exp 16 0 0", st_out, st_bad_data, st_bad_b1);
        end
        checks++;
        if (st_done != 1 || st_err != 0) begin
            errors++; $display("FAIL move_done got done=%0d err=%0d exp 1 0", st_done, st_err);
        end
        @(posedge clk); #1;
        checks++;
        if (o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
            errors++; $display("FAIL move_idle got busy=%b done=%b exp 0 0", o_busy, o_frame_done);
        end
    endtask

    task automatic test_sobel();
        start(1'b1, IW * IH);
        run_frame(IW * IH, 1'b1, 30, 0, 0, 90000);
        checks++;
        if (st_hung !== 1'b0) begin errors++; $display("FAIL sobel_hung got %b exp 0", st_hung); end
        checks++;
        if (st_in != 10000 || st_out != 10000) begin
            errors++; $display("FAIL sobel_counts got in=%0d out=%0d exp 10000 10000", st_in, st_out);
        end
        checks++;
        if (st_bad_data != 0 || st_bad_b0 != 0 || st_bad_b1 != 0) begin
            errors++;
            $display("FAIL sobel_data got bad=%0d b0bad=%0d b1bad=%0d exp 0 0 0", st_bad_data, st_bad_b0, st_bad_b1);
        end
        checks++;
        if (st_bad_stall != 0) begin errors++; $display("FAIL sobel_stall got %0d exp 0", st_bad_stall); end
        checks++;
        if (st_en != 1 || st_en_run !== 1'b1 || st_en_num !== AW'(10000)) begin
            errors++;
            $display("FAIL sobel_kick got en=%0d run=%b num=%0d exp 1 1 10000", st_en, st_en_run, st_en_num);
        end
        checks++;
        if (st_done != 1) begin errors++; $display("FAIL sobel_done got %0d exp 1", st_done); end
    endtask

    task automatic test_reject_size();
        start(1'b1, 9999);
        s_valid = 1'b1;
        checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reject_size got err=%b busy=%b ready=%b exp 1 0 0", o_err, o_busy, s_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (o_err !== 1'b0 || o_busy !== 1'b0 || b0_ce2 !== 1'b0) begin
            errors++;
            $display("FAIL reject_size_after got err=%b busy=%b ce=%b exp 0 0 0", o_err, o_busy, b0_ce2);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reject_zero();
        int bram_act = 0;
        start(1'b0, 0);
        s_valid = 1'b1;
        checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0) begin
            errors++; $display("FAIL reject_zero got err=%b busy=%b exp 1 0", o_err, o_busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (b0_ce2 || b0_we2 || b1_ce2 || s_ready) bram_act++;
        end
        checks++;
        if (bram_act != 0) begin errors++; $display("FAIL reject_zero_bram got %0d exp 0", bram_act); end
        s_valid = 1'b0;
    endtask

    task automatic test_timeout();
        never_done = 1'b1;
        start(1'b0, 4);
        run_frame(4, 1'b0, 100, 0, 0, 300);
        checks++;
        if (st_err != 1 || st_err_cyc - st_en_cyc != int'(TO)) begin
            errors++;
            $display("FAIL timeout_latency got err=%0d dist=%0d exp 1 %0d", st_err, st_err_cyc - st_en_cyc, TO);
        end
        checks++;
        if (st_done != 0 || o_busy !== 1'b0 || st_out != 0) begin
            errors++;
            $display("FAIL timeout_idle got done=%0d busy=%b out=%0d exp 0 0 0", st_done, o_busy, st_out);
        end
        never_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_kick_and_abort();
        start(1'b0, 8);
        run_frame(8, 1'b0, 100, 5, 0, 300);
        checks++;
        if (st_idle_cyc != st_last_in_cyc + 6 || st_en_cyc != st_idle_cyc + 1 || st_en != 1) begin
            errors++;
            $display("FAIL kick_idle got idle=%0d en_at=%0d en=%0d exp %0d %0d 1",
                     st_idle_cyc, st_en_cyc, st_en, st_last_in_cyc + 6, st_last_in_cyc + 7);
        end
        checks++;
        if (st_done != 1 || st_out != 8 || st_bad_data != 0) begin
            errors++;
            $display("FAIL kick_frame got done=%0d out=%0d bad=%0d exp 1 8 0", st_done, st_out, st_bad_data);
        end
        start(1'b0, 16);
        run_frame(16, 1'b0, 50, 0, 5, 300);
        checks++;
        if (o_busy !== 1'b1 || st_out != 5) begin
            errors++; $display("FAIL abort_pre got busy=%b out=%0d exp 1 5", o_busy, st_out);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL abort_outputs got %h exp 0", all_out);
        end
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        start(1'b0, 16);
        run_frame(16, 1'b0, 100, 0, 0, 300);
        checks++;
        if (st_done != 1 || st_in != 16 || st_out != 16 || st_bad_data != 0 || st_bad_b0 != 0) begin
            errors++;
            $display("FAIL restart_frame got done=%0d in=%0d out=%0d bad=%0d b0bad=%0d exp 1 16 16 0 0",
                     st_done, st_in, st_out, st_bad_data, st_bad_b0);
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_reject_size();
        test_reject_zero();
        test_timeout();
        test_kick_and_abort();
        test_sobel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_frame_sequencer.md
Name: sobel_frame_sequencer

Overview:
- Frame-level controller that sequences FSM_Module_Sobel for one frame per command.
- Loads a pixel stream into BRAM0 through its second port, then pulses the filter's enable with the selected mode and waits for its done.
- After the filter finishes, drains BRAM1 through its second port onto an output stream.
- Sits between the camera/host stream interfaces and the Sobel/BRAM subsystem.

Parameters:
- DATA_WIDTH, 8, pixel width.
- ADDR_WIDTH, 16, BRAM address width.
- IMAGE_WIDTH, 100, pixels per line (Sobel mode).
- IMAGE_HEIGHT, 100, lines per frame (Sobel mode).
- TIMEOUT_CYCLES, 65535, maximum cycles to wait for filter done.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle command pulse, sampled only in IDLE.
- i_mode  in  1  1 = Sobel, 0 = move; captured with i_start.
- i_num_pix  in  ADDR_WIDTH  pixel count for the frame; captured with i_start.
- s_valid  in  1  input pixel valid.
- s_data  in  DATA_WIDTH  input pixel.
- s_ready  out  1  input pixel accepted when s_valid & s_ready.
- b0_ce2  out  1  BRAM0 port-2 chip enable.
- b0_we2  out  1  BRAM0 port-2 write enable.
- b0_addr2  out  ADDR_WIDTH  BRAM0 port-2 address.
- b0_d2  out  DATA_WIDTH  BRAM0 port-2 write data.
- b1_ce2  out  1  BRAM1 port-2 chip enable.
- b1_we2  out  1  BRAM1 port-2 write enable; always 0.
- b1_addr2  out  ADDR_WIDTH  BRAM1 port-2 address.
- b1_q2  in  DATA_WIDTH  BRAM1 read data, valid 1 cycle after ce.
- o_f_en  out  1  filter enable pulse (to i_en).
- o_f_run  out  1  filter mode (to i_run).
- o_f_num_cnt  out  ADDR_WIDTH  frame size (to i_num_cnt).
- i_f_idle  in  1  filter o_idle.
- i_f_done  in  1  filter o_done.
- m_valid  out  1  output pixel valid.
- m_data  out  DATA_WIDTH  output pixel.
- m_ready  in  1  output accept.
- o_busy  out  1  high whenever state is not IDLE.
- o_frame_done  out  1  one-cycle pulse after the last output beat.
- o_err  out  1  one-cycle pulse on a rejected command or a timeout.

Behaviour:
- Reset: state = IDLE; all outputs 0; counters, timer and captured registers cleared. Reset mid-frame aborts immediately with no done pulse.
- States: IDLE, LOAD, KICK, WAIT, DRAIN, DONE.
- IDLE:
  - On i_start, capture mode and num.
  - Reject and pulse o_err (stay IDLE) if num == 0, or if mode == 1 and num != IMAGE_WIDTH*IMAGE_HEIGHT.
  - Otherwise go to LOAD with wr_cnt = 0.
  - i_start outside IDLE is ignored.
- LOAD:
  - s_ready = 1.
  - On each accepted beat: b0_ce2 = b0_we2 = 1, b0_addr2 = wr_cnt, b0_d2 = s_data, wr_cnt++ (combinational on the handshake).
  - After the beat with wr_cnt == num-1 is accepted, go to KICK. No extra beat is accepted.
- KICK:
  - Wait until i_f_idle = 1.
  - Then drive o_f_en = 1 for exactly one cycle, with o_f_run = mode and o_f_num_cnt = num.
  - Go to WAIT with timer = 0.
  - o_f_run and o_f_num_cnt hold their captured values from KICK through DRAIN.
- WAIT:
  - timer increments every cycle.
  - On i_f_done, go to DRAIN with rd_cnt = 0.
  - If timer reaches TIMEOUT_CYCLES first: pulse o_err, go to IDLE, no o_frame_done.
  - If i_f_done and timeout occur in the same cycle, done wins.
- DRAIN:
  - Single read in flight plus a one-entry output register.
  - Issue a read (b1_ce2 = 1, b1_addr2 = rd_cnt, rd_cnt++) only when no read is in flight, rd_cnt < num, and the output register is empty or is being accepted this cycle.
  - The cycle after issue, the register loads b1_q2 and m_valid = 1.
  - m_data and m_valid stay stable while m_ready = 0.
  - Maximum throughput is 1 pixel per 2 cycles.
  - When the beat num-1 is accepted, go to DONE.
- DONE: o_frame_done = 1 for one cycle, then IDLE. o_busy drops in the IDLE cycle.
- Width rules:
  - All counters are ADDR_WIDTH bits; no wrap, because num ≤ 2^ADDR_WIDTH-1.
  - The timer is ceil(log2(TIMEOUT_CYCLES+1)) bits.
- b1_we2 = 0 always.
- BRAM port-2 enables are 0 outside LOAD and DRAIN.

Test Plan:
- Move, num = 16, continuous s_valid, m_ready = 1 -> BRAM0[0..15] written in 16 cycles; one o_f_en pulse with o_f_run = 0 and o_f_num_cnt = 16; 16 output beats matching BRAM1 contents; one o_frame_done.
- Sobel, num = 10000, s_valid toggling 50%, m_ready random 30% -> exactly 10000 input and 10000 output beats; output data equals the BRAM1 model; m_data stable under stall.
- i_start with mode = 1, num = 9999 -> o_err pulse the next cycle; stays IDLE; s_ready = 0.
- i_start with num = 0 -> o_err pulse; no BRAM activity.
- Filter model never asserts done, TIMEOUT_CYCLES = 50 -> o_err exactly 50 cycles after entering WAIT; returns to IDLE; o_frame_done = 0.
- KICK with i_f_idle held 0 for 5 cycles -> o_f_en is delayed until i_f_idle = 1, lasts one cycle; rst_n asserted mid-DRAIN -> all outputs 0 immediately; a new start after release completes normally.
